// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the fetch stage
//
// Purpose: word/address types, the {pc, word} record handed to decode,
//          the fetch state encoding, opcode field position and the small
//          arithmetic helpers used by the fetch stage.
// Ports:   none (package).
package fetch_pkg;

   typedef logic [15:0] addr_t;
   typedef logic [15:0] block_t;

   typedef struct packed {
      addr_t  pc;
      block_t word;
   } inst_t;

   typedef enum logic [1:0] {
      FILL = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_e;

   localparam int         OPCODE_MSB      = 15;
   localparam int         OPCODE_LSB      = 12;
   localparam logic [3:0] HALT_OP_DEFAULT = 4'b1111;

   localparam inst_t INST_NOP = '{pc: 16'h0000, word: 16'h0000};

   function automatic logic [3:0] opcode_of(input block_t w);
      return w[OPCODE_MSB:OPCODE_LSB];
   endfunction

   // Modulo-2^16 increment; wrap from FFFF to 0000 is intentional.
   function automatic addr_t pc_inc(input addr_t a);
      return a + 16'd1;
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] c);
      return (c == 16'hFFFF) ? c : c + 16'd1;
   endfunction

endpackage

// File: rtl/fetch.sv
// rtl/fetch.sv - instruction fetch stage of the 16-bit pipeline
//
// Purpose: owns the program counter, drives a 1-cycle synchronous
//          instruction memory and hands one {pc, word} record per cycle to
//          decode. Handles branch/jump redirects, hazard stalls and halt.
// Ports:
//   clk            in   pipeline clock, rising edge
//   rst            in   asynchronous active-low reset
//   stall          in   hazard hold from decode
//   do_branch      in   taken branch from execute (highest priority)
//   branch_address in   branch target
//   do_jump        in   jump from decode
//   jump_address   in   jump target
//   imem_addr      out  memory address, combinational copy of pc
//   imem_rdata     in   memory data, valid the cycle after its address
//   inst           out  registered {pc, word}; NOP is all zeros
//   halted         out  1 while in HALT
//   fetch_count    out  saturating count of words delivered on inst
module fetch
   import fetch_pkg::*;
#(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter logic [3:0]  HALT_OP  = HALT_OP_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        do_branch,
   input  logic [15:0] branch_address,
   input  logic        do_jump,
   input  logic [15:0] jump_address,
   output logic [15:0] imem_addr,
   input  logic [15:0] imem_rdata,
   output logic [31:0] inst,
   output logic        halted,
   output logic [15:0] fetch_count
);

   fetch_state_e state_q, state_d;
   addr_t        pc_q, pc_d;
   addr_t        rd_pc_q, rd_pc_d;
   logic         rd_valid_q, rd_valid_d;
   inst_t        inst_q, inst_d;
   logic [15:0]  count_q, count_d;

   // The memory keeps reading imem_addr (= pc, one ahead of rd_pc) while
   // stalled, so the word belonging to rd_pc would be overwritten after the
   // first stalled edge. It is latched here on that edge and used on release.
   block_t       hold_word_q, hold_word_d;
   logic         hold_valid_q, hold_valid_d;

   logic         redirect;
   addr_t        redirect_pc;
   block_t       rd_word;

   assign redirect    = do_branch | do_jump;
   assign redirect_pc = do_branch ? branch_address : jump_address;
   assign rd_word     = hold_valid_q ? hold_word_q : imem_rdata;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      rd_pc_d      = rd_pc_q;
      rd_valid_d   = rd_valid_q;
      inst_d       = inst_q;
      count_d      = count_q;
      hold_word_d  = hold_word_q;
      hold_valid_d = hold_valid_q;

      if (redirect) begin
         // Redirects override stall and discard the in-flight word.
         pc_d         = redirect_pc;
         rd_valid_d   = 1'b0;
         inst_d       = INST_NOP;
         state_d      = FILL;
         hold_valid_d = 1'b0;
      end else if (stall) begin
         if (state_q == RUN && rd_valid_q && !hold_valid_q) begin
            hold_word_d  = imem_rdata;
            hold_valid_d = 1'b1;
         end
      end else begin
         unique case (state_q)
            FILL: begin
               inst_d     = INST_NOP;
               rd_pc_d    = pc_q;
               rd_valid_d = 1'b1;
               pc_d       = pc_inc(pc_q);
               state_d    = RUN;
            end
            RUN: begin
               hold_valid_d = 1'b0;
               if (rd_valid_q) begin
                  inst_d  = '{pc: rd_pc_q, word: rd_word};
                  count_d = sat_inc(count_q);
                  if (opcode_of(rd_word) == HALT_OP) begin
                     state_d    = HALT;
                     rd_valid_d = 1'b0;
                  end else begin
                     rd_pc_d = pc_q;
                     pc_d    = pc_inc(pc_q);
                  end
               end else begin
                  // No word in flight: behave as a fill cycle.
                  inst_d     = INST_NOP;
                  rd_pc_d    = pc_q;
                  rd_valid_d = 1'b1;
                  pc_d       = pc_inc(pc_q);
               end
            end
            HALT: begin
               inst_d = INST_NOP;
            end
            default: begin
               inst_d  = INST_NOP;
               state_d = FILL;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= FILL;
         pc_q         <= RESET_PC;
         rd_pc_q      <= 16'h0000;
         rd_valid_q   <= 1'b0;
         inst_q       <= INST_NOP;
         count_q      <= 16'h0000;
         hold_word_q  <= 16'h0000;
         hold_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         rd_pc_q      <= rd_pc_d;
         rd_valid_q   <= rd_valid_d;
         inst_q       <= inst_d;
         count_q      <= count_d;
         hold_word_q  <= hold_word_d;
         hold_valid_q <= hold_valid_d;
      end
   end

   assign imem_addr   = pc_q;
   assign inst        = inst_q;
   assign halted      = (state_q == HALT);
   assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch.sv
// tb/tb_fetch.sv - self-checking bench for the fetch stage
module tb_fetch;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall = 1'b0;
   logic        do_branch = 1'b0;
   logic [15:0] branch_address = 16'h0000;
   logic        do_jump = 1'b0;
   logic [15:0] jump_address = 16'h0000;

   logic [15:0] imem_addr1, imem_rdata1, fetch_count1;
   logic [31:0] inst1;
   logic        halted1;
   logic [15:0] imem_addr2, imem_rdata2, fetch_count2;
   logic [31:0] inst2;
   logic        halted2;

   logic [15:0] mem [0:65535];
   logic [31:0] exp_q [$];

   int n_pass  = 0;
   int n_total = 0;

   localparam logic [31:0] NOP = 32'h0000_0000;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      imem_rdata1 <= mem[imem_addr1];
      imem_rdata2 <= mem[imem_addr2];
   end

   fetch #(.RESET_PC(16'h0000), .HALT_OP(4'b1111)) u_dut (
      .clk(clk), .rst(rst), .stall(stall),
      .do_branch(do_branch), .branch_address(branch_address),
      .do_jump(do_jump), .jump_address(jump_address),
      .imem_addr(imem_addr1), .imem_rdata(imem_rdata1),
      .inst(inst1), .halted(halted1), .fetch_count(fetch_count1)
   );

   fetch #(.RESET_PC(16'hFFFE), .HALT_OP(4'b1111)) u_dut_wrap (
      .clk(clk), .rst(rst), .stall(stall),
      .do_branch(do_branch), .branch_address(branch_address),
      .do_jump(do_jump), .jump_address(jump_address),
      .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
      .inst(inst2), .halted(halted2), .fetch_count(fetch_count2)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [31:0] w(input logic [15:0] a);
      return {a, mem[a]};
   endfunction

   // One clock: push the record expected on this edge, then pop and compare.
   task automatic cyc(input string tag, input logic [31:0] e);
      logic [31:0] x;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      x = exp_q.pop_front();
      check_eq(tag, inst1, x);
   endtask

   task automatic redirect(input logic br, input logic [15:0] ba,
                           input logic jp, input logic [15:0] ja);
      do_branch = br; branch_address = ba;
      do_jump = jp;   jump_address = ja;
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = {4'h1, i[11:0]};

      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_inst", inst1, NOP);
      check_eq("rst_halted", {31'd0, halted1}, 32'd0);
      check_eq("rst_count", {16'd0, fetch_count1}, 32'd0);
      check_eq("rst_addr_wrap", {16'd0, imem_addr2}, 32'h0000_FFFE);
      rst = 1'b1;

      // Free run from reset, plus the wrap instance in lockstep.
      cyc("fill_nop", NOP);
      check_eq("wrap_fill", inst2, NOP);
      cyc("run_pc0", w(16'h0000));
      check_eq("wrap_fffe", inst2, w(16'hFFFE));
      cyc("run_pc1", w(16'h0001));
      check_eq("wrap_ffff", inst2, w(16'hFFFF));
      cyc("run_pc2", w(16'h0002));
      check_eq("wrap_0000", inst2, w(16'h0000));
      cyc("run_pc3", w(16'h0003));
      check_eq("count_4", {16'd0, fetch_count1}, 32'd4);
      cyc("run_pc4", w(16'h0004));

      // Jump at pc 5.
      redirect(1'b0, 16'h0000, 1'b1, 16'h0040);
      cyc("jmp_nop0", NOP);
      redirect(1'b0, 16'h0000, 1'b0, 16'h0000);
      cyc("jmp_nop1", NOP);
      cyc("jmp_tgt", w(16'h0040));
      cyc("jmp_tgt1", w(16'h0041));
      check_eq("count_7", {16'd0, fetch_count1}, 32'd7);

      // Branch and jump together: branch wins.
      redirect(1'b1, 16'h0010, 1'b1, 16'h0020);
      cyc("bj_nop0", NOP);
      redirect(1'b0, 16'h0000, 1'b0, 16'h0000);
      cyc("bj_nop1", NOP);
      cyc("bj_tgt", w(16'h0010));
      cyc("bj_tgt1", w(16'h0011));

      // Stall for 3 cycles while {7, mem[7]} is on inst.
      redirect(1'b1, 16'h0006, 1'b0, 16'h0000);
      cyc("st_nop0", NOP);
      redirect(1'b0, 16'h0000, 1'b0, 16'h0000);
      cyc("st_nop1", NOP);
      cyc("st_pc6", w(16'h0006));
      cyc("st_pc7", w(16'h0007));
      stall = 1'b1;
      for (int i = 0; i < 3; i++) cyc("st_hold", w(16'h0007));
      check_eq("st_count_hold", {16'd0, fetch_count1}, 32'd11);
      stall = 1'b0;
      cyc("st_pc8", w(16'h0008));
      cyc("st_pc9", w(16'h0009));
      check_eq("count_13", {16'd0, fetch_count1}, 32'd13);

      // Halt at pc 3.
      mem[3] = 16'hF000;
      redirect(1'b1, 16'h0000, 1'b0, 16'h0000);
      cyc("h_nop0", NOP);
      redirect(1'b0, 16'h0000, 1'b0, 16'h0000);
      cyc("h_nop1", NOP);
      cyc("h_pc0", w(16'h0000));
      cyc("h_pc1", w(16'h0001));
      cyc("h_pc2", w(16'h0002));
      cyc("h_word", 32'h0003_F000);
      check_eq("h_halted", {31'd0, halted1}, 32'd1);
      for (int i = 0; i < 3; i++) cyc("h_nop", NOP);
      check_eq("h_still", {31'd0, halted1}, 32'd1);
      check_eq("h_count", {16'd0, fetch_count1}, 32'd17);

      // Branch out of HALT.
      redirect(1'b1, 16'h0000, 1'b0, 16'h0000);
      cyc("hb_nop0", NOP);
      check_eq("hb_unhalt", {31'd0, halted1}, 32'd0);
      redirect(1'b0, 16'h0000, 1'b0, 16'h0000);
      cyc("hb_nop1", NOP);
      cyc("hb_pc0", w(16'h0000));
      cyc("hb_pc1", w(16'h0001));
      cyc("hb_pc2", w(16'h0002));

      // Jump on the same edge the halt word would be captured.
      redirect(1'b0, 16'h0000, 1'b1, 16'h0020);
      cyc("hj_nop0", NOP);
      check_eq("hj_nohalt", {31'd0, halted1}, 32'd0);
      redirect(1'b0, 16'h0000, 1'b0, 16'h0000);
      cyc("hj_nop1", NOP);
      cyc("hj_tgt", w(16'h0020));

      // Asynchronous reset mid-cycle.
      rst = 1'b0;
      #2;
      check_eq("ar_inst", inst1, NOP);
      check_eq("ar_count", {16'd0, fetch_count1}, 32'd0);
      check_eq("ar_halted", {31'd0, halted1}, 32'd0);
      #1;
      rst = 1'b1;
      cyc("ar_fill", NOP);
      cyc("ar_pc0", w(16'h0000));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
